// File: rtl/d_cache_nway_line_if.sv
// Core data port and sram-like bus port of the N-way D-cache, bundled together.
// The master modport is the cache side; slave is the core/bridge side.
interface d_cache_nway_line_if;
  logic        cpu_data_req;
  logic        cpu_data_wr;
  logic [1:0]  cpu_data_size;
  logic [31:0] cpu_data_addr;
  logic [31:0] cpu_data_wdata;
  logic [31:0] cpu_data_rdata;
  logic        cpu_data_addr_ok;
  logic        cpu_data_data_ok;
  logic        cache_data_req;
  logic        cache_data_wr;
  logic [1:0]  cache_data_size;
  logic [31:0] cache_data_addr;
  logic [31:0] cache_data_wdata;
  logic [31:0] cache_data_rdata;
  logic        cache_data_addr_ok;
  logic        cache_data_data_ok;

  modport master (
    input  cpu_data_req, cpu_data_wr, cpu_data_size, cpu_data_addr, cpu_data_wdata,
    output cpu_data_rdata, cpu_data_addr_ok, cpu_data_data_ok,
    output cache_data_req, cache_data_wr, cache_data_size, cache_data_addr, cache_data_wdata,
    input  cache_data_rdata, cache_data_addr_ok, cache_data_data_ok
  );
  modport slave (
    output cpu_data_req, cpu_data_wr, cpu_data_size, cpu_data_addr, cpu_data_wdata,
    input  cpu_data_rdata, cpu_data_addr_ok, cpu_data_data_ok,
    input  cache_data_req, cache_data_wr, cache_data_size, cache_data_addr, cache_data_wdata,
    output cache_data_rdata, cache_data_addr_ok, cache_data_data_ok
  );
endinterface

// File: rtl/d_cache_nway_line.sv
// Write-back, write-allocate N-way set-associative D-cache with multi-word lines and tree-PLRU.
// Optional DCACHE_PERF_CNT_EN adds perf_hit_cnt / perf_miss_cnt counters.
module d_cache_nway_line #(
  parameter int INDEX_WIDTH     = 6,
  parameter int LINE_WORDS_LOG2 = 2,
  parameter int WAY             = 4
) (
  input  logic clk,
  input  logic rst,
  d_cache_nway_line_if.master cif
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0] perf_hit_cnt,
  output logic [31:0] perf_miss_cnt
`endif
);
  localparam int OW    = LINE_WORDS_LOG2 + 2;
  localparam int TW    = 32 - INDEX_WIDTH - OW;
  localparam int SETS  = 1 << INDEX_WIDTH;
  localparam int WORDS = 1 << LINE_WORDS_LOG2;
  localparam int WW    = $clog2(WAY);
  localparam int CW    = (LINE_WORDS_LOG2 > 0) ? LINE_WORDS_LOG2 : 1;

  typedef enum logic [1:0] {IDLE, WB, RF} state_e;

  logic [TW-1:0]  tag_q   [WAY][SETS];
  logic [31:0]    data_q  [WAY][SETS][WORDS];
  logic [WAY-1:0] valid_q [SETS];
  logic [WAY-1:0] dirty_q [SETS];
  logic [WAY-2:0] plru_q  [SETS];

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   pend_q, pend_d;
  logic [WW-1:0]          vway_q;
  logic [TW-1:0]          vtag_q;
  logic [INDEX_WIDTH-1:0] idx_q;

  logic [TW-1:0]          req_tag;
  logic [INDEX_WIDTH-1:0] req_idx;
  logic [CW-1:0]          req_word;
  logic [WAY-1:0]         hit_mask;
  logic [WW-1:0]          hit_way, vic_way;
  logic                   hit, hit_acc, miss_go, fill_we, fill_last, cnt_last;
  logic [3:0]             bmask;

  assign req_tag  = cif.cpu_data_addr[31:INDEX_WIDTH+OW];
  assign req_idx  = cif.cpu_data_addr[INDEX_WIDTH+OW-1:OW];
  assign req_word = CW'(cif.cpu_data_addr[31:2] & 30'(WORDS-1));
  assign cnt_last = (cnt_q == CW'(WORDS-1));

  // Heap-ordered tree: node n has children 2n+1 / 2n+2; bit 0 = victim on the left.
  function automatic logic [WW-1:0] plru_vic(input logic [WAY-2:0] t);
    int n = 0;
    logic [WW-1:0] w = '0;
    for (int l = 0; l < WW; l++) begin
      w[WW-1-l] = t[n];
      n = 2*n + 1 + int'(t[n]);
    end
    return w;
  endfunction

  function automatic logic [WAY-2:0] plru_touch(input logic [WAY-2:0] t, input logic [WW-1:0] w);
    int n = 0;
    logic [WAY-2:0] r = t;
    for (int l = 0; l < WW; l++) begin
      r[n] = ~w[WW-1-l];
      n = 2*n + 1 + int'(w[WW-1-l]);
    end
    return r;
  endfunction

  always_comb begin
    hit_mask = '0;
    hit_way  = '0;
    for (int w = 0; w < WAY; w++) begin
      hit_mask[w] = valid_q[req_idx][w] && (tag_q[w][req_idx] == req_tag);
      if (hit_mask[w]) hit_way = hit_way | WW'(w);
    end
    hit = |hit_mask;
    vic_way = plru_vic(plru_q[req_idx]);
    for (int w = WAY-1; w >= 0; w--)
      if (!valid_q[req_idx][w]) vic_way = WW'(w);
  end

  always_comb begin
    case (cif.cpu_data_size)
      2'd0:    bmask = 4'b0001 << cif.cpu_data_addr[1:0];
      2'd1:    bmask = cif.cpu_data_addr[1] ? 4'b1100 : 4'b0011;
      default: bmask = 4'b1111;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    hit_acc   = 1'b0;
    miss_go   = 1'b0;
    fill_we   = 1'b0;
    fill_last = 1'b0;
    case (state_q)
      IDLE: if (cif.cpu_data_req) begin
        if (hit) hit_acc = 1'b1;
        else begin
          miss_go = 1'b1;
          state_d = (valid_q[req_idx][vic_way] && dirty_q[req_idx][vic_way]) ? WB : RF;
        end
      end
      WB, RF: begin
        // One word in flight: data_ok retires it, a lone addr_ok parks in pend_q.
        if (cif.cache_data_data_ok) begin
          pend_d  = 1'b0;
          cnt_d   = cnt_q + 1'b1;
          fill_we = (state_q == RF);
          if (cnt_last) begin
            cnt_d     = '0;
            fill_last = (state_q == RF);
            state_d   = (state_q == WB) ? RF : IDLE;
          end
        end else if (cif.cache_data_addr_ok && !pend_q) begin
          pend_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cif.cpu_data_addr_ok = hit_acc;
  assign cif.cpu_data_data_ok = hit_acc;
  assign cif.cpu_data_rdata   = hit_acc ? data_q[hit_way][req_idx][req_word] : '0;
  assign cif.cache_data_req   = (state_q != IDLE) && !pend_q;
  assign cif.cache_data_wr    = (state_q == WB);
  assign cif.cache_data_size  = 2'd2;
  assign cif.cache_data_addr  = {((state_q == WB) ? vtag_q : req_tag), idx_q, {OW{1'b0}}}
                                | (32'(cnt_q) << 2);
  assign cif.cache_data_wdata = (state_q == WB) ? data_q[vway_q][idx_q][cnt_q] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      vway_q  <= '0;
      vtag_q  <= '0;
      idx_q   <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      if (miss_go) begin
        vway_q <= vic_way;
        vtag_q <= tag_q[vic_way][req_idx];
        idx_q  <= req_idx;
      end
      if (fill_last) begin
        valid_q[idx_q][vway_q] <= 1'b1;
        dirty_q[idx_q][vway_q] <= 1'b0;
      end
      if (hit_acc) begin
        plru_q[req_idx] <= plru_touch(plru_q[req_idx], hit_way);
        if (cif.cpu_data_wr) dirty_q[req_idx][hit_way] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; valid_q gates everything read out of them.
  always_ff @(posedge clk) begin
    if (hit_acc && cif.cpu_data_wr)
      for (int b = 0; b < 4; b++)
        if (bmask[b]) data_q[hit_way][req_idx][req_word][8*b +: 8] <= cif.cpu_data_wdata[8*b +: 8];
    if (fill_we) data_q[vway_q][idx_q][cnt_q] <= cif.cache_data_rdata;
    if (fill_last) tag_q[vway_q][idx_q] <= req_tag;
  end

`ifdef DCACHE_PERF_CNT_EN
  logic post_rf_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      post_rf_q     <= 1'b0;
      perf_hit_cnt  <= '0;
      perf_miss_cnt <= '0;
    end else begin
      post_rf_q <= fill_last;
      if (hit_acc && !post_rf_q) perf_hit_cnt <= perf_hit_cnt + 32'd1;
      if (miss_go) perf_miss_cnt <= perf_miss_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_d_cache_nway_line.sv
// Randomized bench for d_cache_nway_line: flat reference memory plus a set/way/PLRU model.
module tb_d_cache_nway_line;
  localparam int IW = 6, LWL = 2, WAY = 4;
  localparam int OW = LWL + 2, WORDS = 1 << LWL, SETS = 1 << IW;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  d_cache_nway_line_if cif();
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] perf_hit_cnt, perf_miss_cnt;
`endif

  d_cache_nway_line #(.INDEX_WIDTH(IW), .LINE_WORDS_LOG2(LWL), .WAY(WAY)) dut (
    .clk(clk),
    .rst(rst),
    .cif(cif)
`ifdef DCACHE_PERF_CNT_EN
    ,
    .perf_hit_cnt(perf_hit_cnt),
    .perf_miss_cnt(perf_miss_cnt)
`endif
  );

  int n_cmp = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Backing store seen by the bus, and what the core should observe.
  logic [31:0] bmem [int unsigned];
  logic [31:0] rmem [int unsigned];
  function automatic logic [31:0] init_w(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction
  function automatic logic [31:0] bm_rd(input logic [31:0] a);
    if (bmem.exists(a)) return bmem[a];
    return init_w(a);
  endfunction
  function automatic logic [31:0] rm_rd(input logic [31:0] a);
    if (rmem.exists(a)) return rmem[a];
    return init_w(a);
  endfunction

  bit          mv [SETS][WAY];
  bit          md [SETS][WAY];
  logic [31:0] mt [SETS][WAY];
  bit [WAY-2:0] mp [SETS];
  int m_hits = 0, m_miss = 0;

  // Tree walk over way ranges: each node halves [lo, lo+sz).
  function automatic int m_victim(input int s);
    int lo = 0, sz = WAY, node = 0;
    while (sz > 1) begin
      sz = sz / 2;
      if (mp[s][node]) begin lo += sz; node = 2*node + 2; end
      else node = 2*node + 1;
    end
    return lo;
  endfunction
  function automatic void m_touch(input int s, input int w);
    int lo = 0, sz = WAY, node = 0;
    while (sz > 1) begin
      sz = sz / 2;
      if (w < lo + sz) begin mp[s][node] = 1'b1; node = 2*node + 1; end
      else begin mp[s][node] = 1'b0; lo += sz; node = 2*node + 2; end
    end
  endfunction

  // Bus bridge: random addr_ok / data_ok delays, or both together when b2b is set.
  logic b2b = 1'b0;
  int   dok_cnt = 0;
  txn_t log_q[$];
  initial begin
    bit pend = 0;
    int wt = 0;
    logic [31:0] pr = '0;
    txn_t e;
    cif.cache_data_addr_ok = 1'b0;
    cif.cache_data_data_ok = 1'b0;
    cif.cache_data_rdata   = '0;
    forever begin
      @(negedge clk);
      cif.cache_data_addr_ok = 1'b0;
      cif.cache_data_data_ok = 1'b0;
      if (rst) begin pend = 0; continue; end
      if (pend) begin
        if (wt == 0) begin
          cif.cache_data_data_ok = 1'b1;
          cif.cache_data_rdata   = pr;
          pend = 0;
          dok_cnt++;
        end else wt--;
      end else if (cif.cache_data_req && (b2b || $urandom_range(0, 2) != 0)) begin
        cif.cache_data_addr_ok = 1'b1;
        e.wr = cif.cache_data_wr; e.addr = cif.cache_data_addr; e.data = cif.cache_data_wdata;
        log_q.push_back(e);
        if (e.wr) bmem[e.addr] = e.data;
        pr = e.wr ? 32'h0 : bm_rd(e.addr);
        if (b2b) begin
          cif.cache_data_data_ok = 1'b1;
          cif.cache_data_rdata   = pr;
          dok_cnt++;
        end else begin
          pend = 1;
          wt = $urandom_range(0, 2);
        end
      end
    end
  end

  logic [31:0] last_rd;
  int          last_cyc;
  task automatic cpu_run(input logic wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    cif.cpu_data_req = 1'b1; cif.cpu_data_wr = wr; cif.cpu_data_size = sz;
    cif.cpu_data_addr = a; cif.cpu_data_wdata = wd;
    last_cyc = 0;
    forever begin
      #1;
      if (cif.cpu_data_data_ok) begin
        chk("addr_ok_with_data_ok", 32'(cif.cpu_data_addr_ok), 32'd1);
        break;
      end
      if (last_cyc > 400) begin chk("cpu_timeout", 32'd0, 32'd1); break; end
      @(negedge clk);
      last_cyc++;
    end
    last_rd = cif.cpu_data_rdata;
    @(posedge clk);
    #1;
    cif.cpu_data_req = 1'b0;
    cif.cpu_data_wr  = 1'b0;
  endtask

  task automatic do_access(input logic wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int s, hw, v, nmin;
    logic [31:0] t, wa, old, nw;
    logic [3:0] m;
    txn_t e;
    txn_t exp_q[$];
    s  = int'((a >> OW) % SETS);
    t  = a >> (OW + IW);
    hw = -1;
    for (int w = 0; w < WAY; w++) if (mv[s][w] && mt[s][w] == t) hw = w;
    if (hw < 0) begin
      m_miss++;
      v = -1;
      for (int w = WAY-1; w >= 0; w--) if (!mv[s][w]) v = w;
      if (v < 0) v = m_victim(s);
      if (mv[s][v] && md[s][v])
        for (int k = 0; k < WORDS; k++) begin
          wa = (mt[s][v] << (OW + IW)) | (32'(s) << OW) | (32'(k) << 2);
          e.wr = 1'b1; e.addr = wa; e.data = rm_rd(wa);
          exp_q.push_back(e);
        end
      for (int k = 0; k < WORDS; k++) begin
        e.wr = 1'b0; e.addr = (t << (OW + IW)) | (32'(s) << OW) | (32'(k) << 2); e.data = '0;
        exp_q.push_back(e);
      end
      mv[s][v] = 1'b1; mt[s][v] = t; md[s][v] = 1'b0;
      hw = v;
    end else m_hits++;
    log_q.delete();
    cpu_run(wr, sz, a, wd);
    chk("n_bus_txn", 32'(log_q.size()), 32'(exp_q.size()));
    nmin = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < nmin; i++) begin
      chk("bus_wr", 32'(log_q[i].wr), 32'(exp_q[i].wr));
      chk("bus_addr", log_q[i].addr, exp_q[i].addr);
      if (exp_q[i].wr) chk("bus_wdata", log_q[i].data, exp_q[i].data);
    end
    if (exp_q.size() == 0) chk("hit_latency", 32'(last_cyc), 32'd0);
    m_touch(s, hw);
    wa = a & ~32'h3;
    if (wr) begin
      md[s][hw] = 1'b1;
      case (sz)
        2'd0:    m = 4'b0001 << a[1:0];
        2'd1:    m = a[1] ? 4'b1100 : 4'b0011;
        default: m = 4'b1111;
      endcase
      old = rm_rd(wa);
      nw  = old;
      for (int b = 0; b < 4; b++) if (m[b]) nw[8*b +: 8] = wd[8*b +: 8];
      rmem[wa] = nw;
    end else chk("load_data", last_rd, rm_rd(wa));
  endtask

  task automatic rand_phase(input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      logic        wr;
      sz = 2'($urandom_range(0, 2));
      a  = (32'($urandom_range(0, 5)) << 10) | (32'($urandom_range(0, 3)) << 4)
         | (32'($urandom_range(0, 3)) << 2);
      if (sz == 2'd0) a |= 32'($urandom_range(0, 3));
      else if (sz == 2'd1) a |= 32'($urandom_range(0, 1)) << 1;
      wr = 1'($urandom_range(0, 1));
      do_access(wr, sz, a, $urandom);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < SETS; s++) begin
      mp[s] = '0;
      for (int w = 0; w < WAY; w++) begin mv[s][w] = 1'b0; md[s][w] = 1'b0; end
    end
    m_hits = 0;
    m_miss = 0;
  endtask

  initial begin
    int dok0, guard;
    logic [31:0] a6;
    cif.cpu_data_req = 1'b0; cif.cpu_data_wr = 1'b0; cif.cpu_data_size = 2'd0;
    cif.cpu_data_addr = '0; cif.cpu_data_wdata = '0;
    for (int k = 0; k < 4; k++) bmem[32'h100 + 32'(4*k)] = 32'hA0 + 32'(k);
    rmem = bmem;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bus_req", 32'(cif.cache_data_req), 32'd0);
    chk("rst_addr_ok", 32'(cif.cpu_data_addr_ok), 32'd0);
    chk("rst_data_ok", 32'(cif.cpu_data_data_ok), 32'd0);
    rst = 1'b0;

    // Cold load then same-line hit
    do_access(1'b0, 2'd2, 32'h100, '0);
    chk("t1_rdata", last_rd, 32'hA0);
    do_access(1'b0, 2'd2, 32'h108, '0);
    chk("t1_hit_rdata", last_rd, 32'hA2);
    chk("t1_hit_cycle", 32'(last_cyc), 32'd0);

    // Byte store merge on a resident line
    do_access(1'b1, 2'd0, 32'h101, 32'h0000_5500);
    do_access(1'b0, 2'd2, 32'h100, '0);
    chk("t2_merge", last_rd, 32'h0000_55A0);

    // Dirty eviction of way 0 at index 0
    for (int t = 0; t < 4; t++) do_access(1'b1, 2'd2, 32'(t) << 10, $urandom);
    do_access(1'b0, 2'd2, 32'(4) << 10, '0);
    chk("t3_ntx", 32'(log_q.size()), 32'(2*WORDS));
    if (log_q.size() > 0) chk("t3_first_wb", log_q[0].addr, 32'h0);

    // PLRU after ways 0,1,2,3,0 evicts way 2 (tag 2) at index 1
    for (int t = 0; t < 4; t++) do_access(1'b0, 2'd2, (32'(t) << 10) | 32'h10, '0);
    do_access(1'b0, 2'd2, 32'h10, '0);
    do_access(1'b0, 2'd2, (32'(5) << 10) | 32'h10, '0);
    do_access(1'b0, 2'd0, (32'(3) << 10) | 32'h10, '0);
    chk("t4_tag3_kept", 32'(log_q.size()), 32'd0);
    do_access(1'b0, 2'd2, (32'(2) << 10) | 32'h10, '0);
    chk("t4_tag2_evicted", 32'(log_q.size()), 32'(WORDS));

    // Same-cycle addr_ok/data_ok bridge, then randomized bridge
    b2b = 1'b1;
    rand_phase(60);
    b2b = 1'b0;
    rand_phase(200);

    // Reset after the second refill word of a cold miss
    a6 = (32'(9) << 10) | (32'(40) << 4);
    dok0 = dok_cnt;
    @(negedge clk);
    cif.cpu_data_req = 1'b1; cif.cpu_data_wr = 1'b0; cif.cpu_data_size = 2'd2; cif.cpu_data_addr = a6;
    guard = 0;
    while (dok_cnt < dok0 + 2 && guard < 200) begin @(negedge clk); #2; guard++; end
    if (guard >= 200) chk("t6_timeout", 32'd0, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    cif.cpu_data_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t6_req_in_rst", 32'(cif.cache_data_req), 32'd0);
    rst = 1'b0;
    model_clear();
    rmem = bmem;
    @(negedge clk);
    chk("t6_req_after_rst", 32'(cif.cache_data_req), 32'd0);
    do_access(1'b0, 2'd2, a6, '0);
    chk("t6_full_refill", 32'(log_q.size()), 32'(WORDS));
    rand_phase(30);
`ifdef DCACHE_PERF_CNT_EN
    @(negedge clk);
    chk("perf_hit", perf_hit_cnt, 32'(m_hits));
    chk("perf_miss", perf_miss_cnt, 32'(m_miss));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/d_cache_nway_line.md
Name: d_cache_nway_line

Overview:
Parametrised write-back, write-allocate, N-way set-associative data cache with multi-word lines. It sits between the MIPS core data port and the AXI-bridge sram-like port. It replaces the fixed 4-way, one-word-per-line D-cache. Line refill and dirty-line write-back run as sequential single-word transactions on the bus side, driven by a word counter.

Parameters:
INDEX_WIDTH, 6, set index bits (sets = 2^INDEX_WIDTH)
LINE_WORDS_LOG2, 2, log2 of 32-bit words per line (0..3); OFFSET_WIDTH = LINE_WORDS_LOG2+2
WAY, 4, associativity; power of 2, 2..8; tree-PLRU uses WAY-1 bits per set

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
cpu_data_req  in  1  core request; held stable until cpu_data_addr_ok
cpu_data_wr  in  1  1 = store
cpu_data_size  in  2  0 = byte, 1 = half, 2 = word
cpu_data_addr  in  32  byte address
cpu_data_wdata  in  32  store data, byte lanes already aligned
cpu_data_rdata  out  32  load data
cpu_data_addr_ok  out  1  request accepted
cpu_data_data_ok  out  1  request complete
cache_data_req  out  1  bus request
cache_data_wr  out  1  bus write
cache_data_size  out  2  always 2
cache_data_addr  out  32  word-aligned bus address
cache_data_wdata  out  32  write-back word
cache_data_rdata  in  32  refill word
cache_data_addr_ok  in  1  bus address accepted
cache_data_data_ok  in  1  bus data done
perf_hit_cnt  out  32  present only with DCACHE_PERF_CNT_EN
perf_miss_cnt  out  32  present only with DCACHE_PERF_CNT_EN

Behaviour:
- Address split: tag = addr[31:INDEX_WIDTH+OFFSET_WIDTH], index, word = addr[OFFSET_WIDTH-1:2].
- Reset:
  - All valid, dirty and PLRU bits are cleared; tag and data arrays are not reset.
  - State goes to IDLE; word counter = 0.
  - All outputs are 0: cache_data_req, cpu_data_addr_ok, cpu_data_data_ok; rdata and wdata read 0 or don't-care with req low.
- Hit is defined as any way with valid && tag match. The match mask is one-hot; the way is encoded generically for any WAY.
- IDLE + req + hit:
  - addr_ok and data_ok are asserted combinationally in the same cycle; zero-wait.
  - Load: rdata = hit way word[word].
  - Store: byte mask from size/addr[1:0] (byte → 1 lane; half → lanes 1:0 or 3:2 by addr[1]; word → all). Selected lanes are merged into the word and dirty is set on the next edge.
  - PLRU is updated toward the hit way.
- IDLE + req + miss:
  - addr_ok = data_ok = 0.
  - Victim = lowest-numbered invalid way, else the tree-PLRU victim.
  - Victim way, tag, index and dirty are latched.
  - Next state: WB if victim valid && dirty, else RF.
- WB:
  - For k = 0..2^LINE_WORDS_LOG2-1, in order: req=1, wr=1, addr = {victim_tag, index, k, 2'b00}, wdata = victim word k.
  - req drops after addr_ok and stays low until data_ok; only one transaction is outstanding.
  - data_ok increments k. addr_ok and data_ok may arrive in the same cycle.
  - After the last word: k = 0, go to RF.
- RF:
  - Same handshake with wr=0, addr = {req_tag, index, k, 2'b00}.
  - Each data_ok writes cache_data_rdata into victim word k.
  - On the last data_ok: valid=1, dirty=0, tag=req_tag; go to IDLE.
  - The held core request then hits in the following cycle, including store merge, dirty set and PLRU update.
  - Loads and stores both allocate.
- Latency:
  - Clean miss: 2^LINE_WORDS_LOG2 bus transactions + 1 cycle.
  - Dirty miss: 2×2^LINE_WORDS_LOG2 transactions + 1 cycle.
- Tree-PLRU (per set):
  - Node bit 0 means the victim is in the left subtree.
  - On access, each node on the path is set to point away from the accessed way.
  - Victim is found by following the node bits from the root.
- Core protocol rule: the core must not change or drop a request before addr_ok. Behaviour when it does is undefined and not checked.
- Reset mid-WB or mid-RF:
  - The current transaction is abandoned; the bus bridge is reset together with the cache.
  - The cache comes out empty.
  - A partially refilled line is never marked valid.

Optional Feature:
DCACHE_PERF_CNT_EN: when defined, the block adds 32-bit perf_hit_cnt and perf_miss_cnt ports.
- Both counters reset to 0 and wrap at 2^32.
- hit increments once per core request that hits in IDLE on first presentation.
- miss increments once per IDLE→WB/RF transition.
- The post-refill hit is not counted as a hit.
When the macro is undefined: the ports and counters are absent, and all other behaviour is identical.

Test Plan:
1. Defaults, cold load at 0x0000_0100 → four bus reads to 0x100, 0x104, 0x108, 0x10C with rdata 0xA0..0xA3. Required response: cpu data_ok with rdata 0xA0. A following load of 0x108 hits the same cycle with rdata 0xA2.
2. Store byte 0x55 to 0x101 (size 0) on a resident line holding 0xA0 → no bus activity, same-cycle data_ok. Load 0x100 returns 0x0000_55A0 and the line is dirty.
3. Dirty eviction: stores fill tags 0..3 at index 0, then load tag 4 → four writes of the PLRU victim (way 0) words 0..3 in order, then four reads, then data_ok.
4. PLRU order: after accesses to ways 0, 1, 2, 3, 0, a miss evicts way 2. With WAY=2 and WAY=8 builds, the victim sequence matches the tree model.
5. Back-to-back handshake: bridge asserts addr_ok and data_ok in the same cycle for every word → the counter advances each word, with no duplicate or skipped addresses.
6. rst asserted after the second refill word → valid bits are clear and bus req is 0. The next load to the same address performs a full 4-word refill.
